// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer for the 5-stage core: arbitrates memory freeze, redirect and
// load-use stall into stage enables, NOP injection and PC select, plus event counters.
//
// state    | meaning
// RUN      | normal issue; requests resolved by priority mem_busy > redirect > stall
// FLUSH    | post-redirect shadow, de keeps receiving NOPs for flush_left more cycles
// WAIT_MEM | pipe frozen on data memory; a redirect seen meanwhile is held pending
module pipe_seq_ctrl #(
   parameter int FLUSH_CYCLES  = 2,
   parameter int STALL_TIMEOUT = 8,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_req,
   input  logic             redirect_req,
   input  logic             mem_busy,
   input  logic             clr_cnt,
   output logic             en_fetch,
   output logic             en_de,
   output logic             en_exe,
   output logic             en_acc,
   output logic             en_wb,
   output logic             flush_de,
   output logic             flush_exe,
   output logic             pc_sel_redirect,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] cnt_stall,
   output logic [CNT_W-1:0] cnt_flush,
   output logic [CNT_W-1:0] cnt_mem
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_FLUSH    = 2'd1;
   localparam logic [1:0] ST_WAIT_MEM = 2'd2;

   localparam int              SR_W       = $clog2(STALL_TIMEOUT + 1);
   localparam logic [SR_W-1:0] SR_MAX     = SR_W'(STALL_TIMEOUT);
   localparam logic [SR_W-1:0] SR_LAST    = SR_W'(STALL_TIMEOUT - 1);
   localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   logic [1:0]      state, state_nxt;
   logic [2:0]      flush_left, flush_left_nxt;
   logic [SR_W-1:0] stall_run, stall_run_nxt;
   logic            redirect_pend, redirect_pend_nxt;
   logic            eff_redirect;
   logic [4:0]      en_vec;
   logic            fde, fexe, pcs;
   logic            ev_stall, ev_flush, ev_mem, err_proto, stall_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
      return (ev && (v != '1)) ? v + 1'b1 : v;
   endfunction

   always_comb begin
      en_vec            = 5'b00000;
      fde               = 1'b0;
      fexe              = 1'b0;
      pcs               = 1'b0;
      state_nxt         = state;
      flush_left_nxt    = flush_left;
      redirect_pend_nxt = redirect_pend;
      ev_stall          = 1'b0;
      ev_flush          = 1'b0;
      ev_mem            = 1'b0;
      err_proto         = 1'b0;
      // A redirect captured while frozen is replayed on the release cycle.
      eff_redirect      = redirect_req | ((state == ST_WAIT_MEM) & redirect_pend);
      case (state)
         ST_RUN, ST_WAIT_MEM: begin
            if (mem_busy) begin
               state_nxt         = ST_WAIT_MEM;
               redirect_pend_nxt = eff_redirect;
               ev_mem            = 1'b1;
            end else if (eff_redirect) begin
               en_vec            = 5'b11111;
               pcs               = 1'b1;
               fde               = 1'b1;
               fexe              = 1'b1;
               ev_flush          = 1'b1;
               redirect_pend_nxt = 1'b0;
               if (FLUSH_CYCLES > 1) begin
                  state_nxt      = ST_FLUSH;
                  flush_left_nxt = FLUSH_INIT;
               end else begin
                  state_nxt      = ST_RUN;
               end
            end else if (stall_req) begin
               en_vec    = 5'b00111;
               fexe      = 1'b1;
               ev_stall  = 1'b1;
               state_nxt = ST_RUN;
            end else begin
               en_vec    = 5'b11111;
               state_nxt = ST_RUN;
            end
         end
         ST_FLUSH: begin
            // exe holds a bubble here, so a redirect cannot legally arrive.
            err_proto = redirect_req;
            if (mem_busy) begin
               ev_mem = 1'b1;
            end else begin
               en_vec         = 5'b11111;
               fde            = 1'b1;
               ev_flush       = 1'b1;
               flush_left_nxt = flush_left - 3'd1;
               if (flush_left <= 3'd1) state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   assign stall_hit     = stall_req && (stall_run >= SR_LAST);
   assign stall_run_nxt = !stall_req ? '0 : (stall_run == SR_MAX) ? SR_MAX : stall_run + 1'b1;

   assign {en_fetch, en_de, en_exe, en_acc, en_wb} = rst ? en_vec : 5'b00000;
   assign flush_de        = rst & fde;
   assign flush_exe       = rst & fexe;
   assign pc_sel_redirect = rst & pcs;
   assign busy            = rst & (state != ST_RUN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_RUN;
         flush_left    <= '0;
         stall_run     <= '0;
         redirect_pend <= 1'b0;
         err           <= 1'b0;
         cnt_stall     <= '0;
         cnt_flush     <= '0;
         cnt_mem       <= '0;
      end else begin
         state         <= state_nxt;
         flush_left    <= flush_left_nxt;
         stall_run     <= stall_run_nxt;
         redirect_pend <= redirect_pend_nxt;
         if (clr_cnt) begin
            err       <= 1'b0;
            cnt_stall <= '0;
            cnt_flush <= '0;
            cnt_mem   <= '0;
         end else begin
            err       <= err | err_proto | stall_hit;
            cnt_stall <= sat_inc(cnt_stall, ev_stall);
            cnt_flush <= sat_inc(cnt_flush, ev_flush);
            cnt_mem   <= sat_inc(cnt_mem, ev_mem);
         end
      end
   end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed bench for pipe_seq_ctrl: linear stimulus with hand-computed expectations
// on the packed control outputs, err and the event counters.
module tb_pipe_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_req = 1'b0, redirect_req = 1'b0, mem_busy = 1'b0, clr_cnt = 1'b0;
   logic        en_fetch, en_de, en_exe, en_acc, en_wb;
   logic        flush_de, flush_exe, pc_sel_redirect, busy, err;
   logic [15:0] cnt_stall, cnt_flush, cnt_mem;
   logic [8:0]  outs;
   int          checks = 0;
   int          failures = 0;

   // outs = {en_fetch,en_de,en_exe,en_acc,en_wb, flush_de, flush_exe, pc_sel_redirect, busy}
   localparam logic [8:0] O_RESET   = 9'b00000_0_0_0_0;
   localparam logic [8:0] O_IDLE    = 9'b11111_0_0_0_0;
   localparam logic [8:0] O_STALL   = 9'b00111_0_1_0_0;
   localparam logic [8:0] O_REDIR   = 9'b11111_1_1_1_0;
   localparam logic [8:0] O_FLUSH   = 9'b11111_1_0_0_1;
   localparam logic [8:0] O_FRZ_RUN = 9'b00000_0_0_0_0;
   localparam logic [8:0] O_FRZ_BSY = 9'b00000_0_0_0_1;
   localparam logic [8:0] O_REL_RED = 9'b11111_1_1_1_1;

   pipe_seq_ctrl #(.FLUSH_CYCLES(2), .STALL_TIMEOUT(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .stall_req(stall_req), .redirect_req(redirect_req),
      .mem_busy(mem_busy), .clr_cnt(clr_cnt),
      .en_fetch(en_fetch), .en_de(en_de), .en_exe(en_exe), .en_acc(en_acc), .en_wb(en_wb),
      .flush_de(flush_de), .flush_exe(flush_exe), .pc_sel_redirect(pc_sel_redirect),
      .busy(busy), .err(err), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush), .cnt_mem(cnt_mem)
   );

   assign outs = {en_fetch, en_de, en_exe, en_acc, en_wb, flush_de, flush_exe, pc_sel_redirect, busy};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic r, input logic m, input logic c);
      stall_req    = s;
      redirect_req = r;
      mem_busy     = m;
      clr_cnt      = c;
      #1;
   endtask

   task automatic chk_cnt(input string tag, input int es, input int ef, input int em);
      chk({tag, "_cnt_stall"}, 32'(cnt_stall), es);
      chk({tag, "_cnt_flush"}, 32'(cnt_flush), ef);
      chk({tag, "_cnt_mem"},   32'(cnt_mem),   em);
   endtask

   initial begin
      // reset held
      #2;
      chk("rst_outs", 32'(outs), 32'(O_RESET));
      chk("rst_err", 32'(err), 0);
      chk_cnt("rst", 0, 0, 0);
      tick(); tick();
      chk("rst_outs_held", 32'(outs), 32'(O_RESET));

      // idle
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0, 0);
         chk("idle_outs", 32'(outs), 32'(O_IDLE));
         tick();
      end
      chk_cnt("idle", 0, 0, 0);

      // single stall
      drive(1, 0, 0, 0);
      chk("stall_outs", 32'(outs), 32'(O_STALL));
      tick();
      drive(0, 0, 0, 0);
      chk("stall_after", 32'(outs), 32'(O_IDLE));
      chk("stall_cnt", 32'(cnt_stall), 1);

      // redirect, stall in the same cycle is dropped
      drive(1, 1, 0, 0);
      chk("redir_c0", 32'(outs), 32'(O_REDIR));
      tick();
      drive(0, 0, 0, 0);
      chk("redir_c1", 32'(outs), 32'(O_FLUSH));
      tick();
      drive(0, 0, 0, 0);
      chk("redir_c2", 32'(outs), 32'(O_IDLE));
      chk_cnt("redir", 1, 2, 0);

      // memory wait with pending redirect
      drive(0, 1, 1, 0);
      chk("mem_c0", 32'(outs), 32'(O_FRZ_RUN));
      tick();
      drive(0, 0, 1, 0);
      chk("mem_c1", 32'(outs), 32'(O_FRZ_BSY));
      tick();
      drive(0, 0, 1, 0);
      chk("mem_c2", 32'(outs), 32'(O_FRZ_BSY));
      tick();
      drive(0, 0, 0, 0);
      chk("mem_release", 32'(outs), 32'(O_REL_RED));
      tick();
      drive(0, 0, 0, 0);
      chk("mem_flush", 32'(outs), 32'(O_FLUSH));
      tick();
      drive(0, 0, 0, 0);
      chk("mem_done", 32'(outs), 32'(O_IDLE));
      chk_cnt("mem", 1, 4, 3);

      // watchdog: 7 cycles is still legal, the 8th sets err
      for (int i = 0; i < 7; i++) begin
         drive(1, 0, 0, 0);
         tick();
      end
      chk("wd_7_err", 32'(err), 0);
      drive(1, 0, 0, 0);
      tick();
      chk("wd_8_err", 32'(err), 1);
      drive(0, 0, 0, 0);
      tick();
      chk("wd_sticky", 32'(err), 1);
      chk("wd_cnt_stall", 32'(cnt_stall), 9);

      // clear, with a stall bubble in the same cycle (clear wins)
      drive(1, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0);
      chk("clr_err", 32'(err), 0);
      chk_cnt("clr", 0, 0, 0);
      tick();

      // redirect during FLUSH is ignored and flagged
      drive(0, 1, 0, 0);
      tick();
      drive(0, 1, 0, 0);
      chk("fl_redir_outs", 32'(outs), 32'(O_FLUSH));
      tick();
      drive(0, 0, 0, 0);
      chk("fl_redir_err", 32'(err), 1);
      chk("fl_redir_back", 32'(outs), 32'(O_IDLE));
      drive(0, 0, 0, 1);
      tick();

      // mem_busy during FLUSH freezes and holds flush_left
      drive(0, 1, 0, 0);
      tick();
      drive(0, 0, 1, 0);
      chk("fl_mem_frz", 32'(outs), 32'(O_FRZ_BSY));
      tick();
      drive(0, 0, 0, 0);
      chk("fl_mem_resume", 32'(outs), 32'(O_FLUSH));
      tick();
      drive(0, 0, 0, 0);
      chk("fl_mem_done", 32'(outs), 32'(O_IDLE));
      chk("fl_mem_err", 32'(err), 0);
      chk_cnt("fl_mem", 0, 2, 1);

      // reset mid-FLUSH
      drive(0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0);
      chk("rmid_flush", 32'(outs), 32'(O_FLUSH));
      #1;
      rst = 1'b0;
      #1;
      chk("rmid_outs", 32'(outs), 32'(O_RESET));
      chk_cnt("rmid", 0, 0, 0);
      tick();
      rst = 1'b1;
      #1;
      chk("rmid_rel", 32'(outs), 32'(O_IDLE));
      tick();
      chk("rmid_rel2", 32'(outs), 32'(O_IDLE));
      chk("rmid_cnt_flush", 32'(cnt_flush), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
